// File: rtl/sp_instr_issue.sv
// Issue stage in front of the scratchpad instruction FIFO: holds one instruction,
// checks it against in-flight loads and the in-flight GEMM, and pushes it in program order.
module sp_instr_issue #(
    parameter int unsigned MatSW = 4,
    parameter int unsigned RowSW = 2,
    parameter int unsigned WordW = 32,
    parameter int unsigned MaxLd = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             instr_valid_i,
    output logic                             instr_ready_o,
    input  logic [1:0]                       instr_op_i,
    input  logic [MatSW-1:0]                 instr_rd_i,
    input  logic [WordW-1:0]                 instr_addr_i,
    input  logic [MatSW-1:0]                 instr_ma_i,
    input  logic [MatSW-1:0]                 instr_mb_i,
    input  logic [MatSW-1:0]                 instr_mc_i,
    input  logic [MatSW-1:0]                 instr_md_i,
    input  logic                             instr_new_weight_i,
    input  logic                             instr_fifo_full_i,
    output logic                             instr_fifo_wen_o,
    output logic [2+MatSW+RowSW+WordW-1:0]   instr_fifo_wdata_o,
    input  logic                             load_complete_i,
    input  logic                             gemm_complete_i,
    output logic [15:0]                      stall_cnt_o,
    output logic                             protocol_err_o
);

    localparam int unsigned NumMat = 2 ** MatSW;
    localparam int unsigned EntryW = 2 + MatSW + RowSW + WordW;
    localparam int unsigned PtrW   = (MaxLd > 1) ? $clog2(MaxLd) : 1;
    localparam int unsigned CntW   = $clog2(MaxLd + 1);

    localparam logic [1:0] OpLoad  = 2'b01;
    localparam logic [1:0] OpStore = 2'b10;
    localparam logic [1:0] OpGemm  = 2'b11;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [MatSW-1:0]     rd_q, rd_d, ma_q, ma_d, mb_q, mb_d, mc_q, mc_d, md_q, md_d;
    logic [WordW-1:0]     addr_q, addr_d;
    logic                 nw_q, nw_d;

    logic [MatSW-1:0]     ldq_q [MaxLd];
    logic [MatSW-1:0]     ldq_d [MaxLd];
    logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NumMat-1:0]    pend_q, pend_d;

    logic                 gbusy_q, gbusy_d;
    logic [MatSW-1:0]     ga_q, ga_d, gb_q, gb_d, gc_q, gc_d, gd_q, gd_d;

    logic [15:0]          stall_q, stall_d;
    logic                 err_q, err_d;

    logic hold_v, hazard, issue, accept, ldq_full, push, pop, in_gemm;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxLd - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign hold_v   = (state_q == StFull);
    assign ldq_full = (cnt_q == CntW'(MaxLd));
    assign in_gemm  = gbusy_q & ((rd_q == ga_q) | (rd_q == gb_q) |
                                 (rd_q == gc_q) | (rd_q == gd_q));

    // Hazards look only at registered state, so a completion frees its resource next cycle.
    always_comb begin
        hazard = 1'b0;
        case (op_q)
            OpLoad:  hazard = pend_q[rd_q] | ldq_full | in_gemm;
            OpStore: hazard = pend_q[rd_q] | (gbusy_q & (rd_q == gd_q));
            OpGemm:  hazard = gbusy_q | pend_q[ma_q] | pend_q[mb_q] | pend_q[mc_q] | pend_q[md_q];
            default: hazard = 1'b0;
        endcase
    end

    assign issue            = ~rst_i & hold_v & ~hazard & ~instr_fifo_full_i;
    assign instr_ready_o    = ~rst_i & (~hold_v | issue);
    assign accept           = instr_valid_i & instr_ready_o;
    assign instr_fifo_wen_o = issue;
    assign push             = issue & (op_q == OpLoad);
    assign pop              = load_complete_i & (cnt_q != '0);
    assign stall_cnt_o      = stall_q;
    assign protocol_err_o   = err_q;

    always_comb begin
        instr_fifo_wdata_o = '0;
        if (issue) begin
            if (op_q == OpGemm) begin
                instr_fifo_wdata_o[EntryW-1 -: 2]   = OpGemm;
                instr_fifo_wdata_o[EntryW-3]        = nw_q;
                instr_fifo_wdata_o[4*MatSW-1:0]     = {ma_q, mb_q, mc_q, md_q};
            end else begin
                instr_fifo_wdata_o = {op_q, rd_q, {RowSW{1'b0}}, addr_q};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        mc_d    = mc_q;
        md_d    = md_q;
        nw_d    = nw_q;
        ldq_d   = ldq_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        gbusy_d = gbusy_q;
        ga_d    = ga_q;
        gb_d    = gb_q;
        gc_d    = gc_q;
        gd_d    = gd_q;
        stall_d = stall_q;
        err_d   = err_q;

        if (issue) begin
            state_d = StEmpty;
        end
        if (accept) begin
            if (instr_op_i == 2'b00) begin
                err_d = 1'b1;
            end else begin
                state_d = StFull;
                op_d    = instr_op_i;
                rd_d    = instr_rd_i;
                addr_d  = instr_addr_i;
                ma_d    = instr_ma_i;
                mb_d    = instr_mb_i;
                mc_d    = instr_mc_i;
                md_d    = instr_md_i;
                nw_d    = instr_new_weight_i;
            end
        end

        // Pop before push: a LOAD only issues when its id is not pending, so no bit collision.
        if (pop) begin
            pend_d[ldq_q[head_q]] = 1'b0;
            head_d                = ptr_inc(head_q);
        end
        if (push) begin
            ldq_d[tail_q] = rd_q;
            pend_d[rd_q]  = 1'b1;
            tail_d        = ptr_inc(tail_q);
        end
        if (push & ~pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop & ~push) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (load_complete_i & (cnt_q == '0)) begin
            err_d = 1'b1;
        end

        if (gemm_complete_i) begin
            if (gbusy_q) begin
                gbusy_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (issue & (op_q == OpGemm)) begin
            gbusy_d = 1'b1;
            ga_d    = ma_q;
            gb_d    = mb_q;
            gc_d    = mc_q;
            gd_d    = md_q;
        end

        if (hold_v & ~issue & (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            gbusy_q <= 1'b0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            gbusy_q <= gbusy_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    // Payload registers are qualified by the control state above and need no reset.
    always_ff @(posedge clk_i) begin
        op_q   <= op_d;
        rd_q   <= rd_d;
        addr_q <= addr_d;
        ma_q   <= ma_d;
        mb_q   <= mb_d;
        mc_q   <= mc_d;
        md_q   <= md_d;
        nw_q   <= nw_d;
        ldq_q  <= ldq_d;
        ga_q   <= ga_d;
        gb_q   <= gb_d;
        gc_q   <= gc_d;
        gd_q   <= gd_d;
    end

endmodule

// File: tb/tb_sp_instr_issue.sv
// Randomised bench for sp_instr_issue: a queue-based reference model predicts handshake,
// issue timing and counters; a scoreboard checks FIFO entries in program order.
module tb_sp_instr_issue;

    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  rd;
        logic [31:0] addr;
        logic [3:0]  ma, mb, mc, md;
        logic        nw;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ready, nw, full, wen, lc, gc, perr;
    logic [1:0]  op;
    logic [3:0]  rd, ma, mb, mc, md;
    logic [31:0] addr;
    logic [39:0] wdata;
    logic [15:0] stall;

    always #5 clk = ~clk;

    sp_instr_issue dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .instr_valid_i      (valid),
        .instr_ready_o      (ready),
        .instr_op_i         (op),
        .instr_rd_i         (rd),
        .instr_addr_i       (addr),
        .instr_ma_i         (ma),
        .instr_mb_i         (mb),
        .instr_mc_i         (mc),
        .instr_md_i         (md),
        .instr_new_weight_i (nw),
        .instr_fifo_full_i  (full),
        .instr_fifo_wen_o   (wen),
        .instr_fifo_wdata_o (wdata),
        .load_complete_i    (lc),
        .gemm_complete_i    (gc),
        .stall_cnt_o        (stall),
        .protocol_err_o     (perr)
    );

    int          checks = 0;
    int          failures = 0;
    bit          started = 0;
    logic [39:0] sb[$];

    // Reference model state
    bit          m_hold;
    instr_t      m_ins;
    int          m_ldq[$];
    bit          m_gbusy;
    logic [3:0]  m_g[4];
    int          m_stall;
    bit          m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] encode(input instr_t i);
        if (i.op == 2'b11) return {2'b11, i.nw, 3'b000, 2'b00, 16'h0000, i.ma, i.mb, i.mc, i.md};
        return {i.op, i.rd, 2'b00, i.addr};
    endfunction

    function automatic bit in_ldq(input logic [3:0] m);
        foreach (m_ldq[i]) if (m_ldq[i] == int'(m)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_gemm(input logic [3:0] m);
        return m_gbusy && (m == m_g[0] || m == m_g[1] || m == m_g[2] || m == m_g[3]);
    endfunction

    function automatic bit hazard();
        case (m_ins.op)
            2'b01: return in_ldq(m_ins.rd) || m_ldq.size() >= 4 || in_gemm(m_ins.rd);
            2'b10: return in_ldq(m_ins.rd) || (m_gbusy && m_ins.rd == m_g[3]);
            2'b11: return m_gbusy || in_ldq(m_ins.ma) || in_ldq(m_ins.mb) ||
                          in_ldq(m_ins.mc) || in_ldq(m_ins.md);
            default: return 1'b0;
        endcase
    endfunction

    // Driver + timing model: inputs change on the falling edge, predictions settle 1 unit later.
    initial begin
        bit     exp_issue, exp_ready;
        instr_t nxt;
        int     r;
        rst = 1'b1; valid = 1'b0; op = '0; rd = '0; addr = '0; ma = '0; mb = '0; mc = '0;
        md = '0; nw = 1'b0; full = 1'b0; lc = 1'b0; gc = 1'b0;
        m_hold = 0; m_gbusy = 0; m_stall = 0; m_err = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst   = (cyc < 2) || ($urandom_range(0, 299) == 0);
            r     = $urandom_range(0, 99);
            nxt.op   = (r < 5) ? 2'b00 : (r < 45) ? 2'b01 : (r < 70) ? 2'b10 : 2'b11;
            nxt.rd   = 4'($urandom_range(0, 7));
            nxt.addr = $urandom;
            nxt.ma   = 4'($urandom_range(0, 7));
            nxt.mb   = 4'($urandom_range(0, 7));
            nxt.mc   = 4'($urandom_range(0, 7));
            nxt.md   = 4'($urandom_range(0, 7));
            nxt.nw   = 1'($urandom_range(0, 1));
            valid = ($urandom_range(0, 99) < 70);
            {op, rd, addr, ma, mb, mc, md, nw} = nxt;
            full  = ($urandom_range(0, 99) < 20);
            lc    = (m_ldq.size() > 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 2);
            gc    = m_gbusy ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 2);
            #1;
            exp_issue = !rst && m_hold && !hazard() && !full;
            exp_ready = !rst && (!m_hold || exp_issue);
            check("instr_ready", 64'(ready), 64'(exp_ready));
            check("fifo_wen", 64'(wen), 64'(exp_issue));
            if (started) begin
                check("stall_cnt", 64'(stall), 64'(m_stall));
                check("protocol_err", 64'(perr), 64'(m_err));
            end
            if (rst) begin
                m_hold = 0; m_ldq.delete(); m_gbusy = 0; m_stall = 0; m_err = 0; sb.delete();
            end else begin
                if (lc) begin
                    if (m_ldq.size() > 0) void'(m_ldq.pop_front());
                    else m_err = 1;
                end
                if (gc) begin
                    if (m_gbusy) m_gbusy = 0;
                    else m_err = 1;
                end
                if (exp_issue && m_ins.op == 2'b01) m_ldq.push_back(int'(m_ins.rd));
                if (exp_issue && m_ins.op == 2'b11) begin
                    m_gbusy = 1;
                    m_g[0] = m_ins.ma; m_g[1] = m_ins.mb; m_g[2] = m_ins.mc; m_g[3] = m_ins.md;
                end
                if (m_hold && !exp_issue && m_stall < 65535) m_stall++;
                if (exp_issue) m_hold = 0;
                if (valid && exp_ready) begin
                    if (nxt.op == 2'b00) begin
                        m_err = 1;
                    end else begin
                        m_hold = 1;
                        m_ins  = nxt;
                        sb.push_back(encode(nxt));
                    end
                end
            end
            started = 1;
        end
        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: every push must match the oldest accepted instruction; idle wdata must be zero.
    initial begin
        logic [39:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (started) begin
                if (wen === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_underflow actual=%0h required=none at %0t", wdata, $time);
                    end else begin
                        exp = sb.pop_front();
                        check("fifo_wdata", 64'(wdata), 64'(exp));
                    end
                end else begin
                    check("wdata_idle", 64'(wdata), 64'd0);
                end
            end
        end
    end

endmodule
